// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register and later serialiser blocks.
//   mode_t      : 3-bit operation select
//   MODE_*      : operation encodings; 3'b111 is reserved and behaves as HOLD
package univ_shift_reg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD     = 3'b000;
    localparam mode_t MODE_LOAD     = 3'b001;
    localparam mode_t MODE_CLEAR    = 3'b010;
    localparam mode_t MODE_SHIFT_UP = 3'b011;
    localparam mode_t MODE_SHIFT_DN = 3'b100;
    localparam mode_t MODE_ROT_UP   = 3'b101;
    localparam mode_t MODE_ROT_DN   = 3'b110;

endpackage

// File: rtl/shift_frame_ctr.sv
// Shift-frame counter: counts shift/rotate steps and pulses frame_done for one
// cycle after the WIDTH-th consecutive step. State updates on the falling edge.
//   ck         : clock (falling edge active)
//   rst_n      : asynchronous active-low reset
//   step       : a shift or rotate is performed on this edge
//   restart    : load/clear on this edge; abandons the current frame silently
//   shift_cnt  : steps taken in the current frame
//   frame_done : one-cycle pulse after the final step of a frame
module shift_frame_ctr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             step,
    input  logic             restart,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (step) begin
            if (cnt_q == LastCnt) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt  = cnt_q;
    assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, load, clear, shift up/down with
// serial inputs and rotate up/down, plus a shift-frame counter for SIPO/PISO use.
// All state updates on the falling edge of ck.
//   ck, rst_n         : clock (falling edge), asynchronous active-low reset
//   mode              : operation select (see univ_shift_reg_pkg)
//   sin_up, sin_dn    : serial inputs entering q[0] / q[WIDTH-1]
//   d                 : parallel load data
//   q                 : register contents
//   sout_up, sout_dn  : q[WIDTH-1] / q[0], the bits shifted out
//   shift_cnt         : steps since last frame boundary, load, clear or reset
//   frame_done        : one-cycle pulse after a WIDTH-step frame
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             ck,
    input  logic             rst_n,
    input  mode_t            mode,
    input  logic             sin_up,
    input  logic             sin_dn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_up,
    output logic             sout_dn,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             step;
    logic             restart;

    // sin_* only reach q_d in their own shift mode, so an undriven serial
    // input cannot leak X into the register.
    always_comb begin
        q_d     = q_q;
        step    = 1'b0;
        restart = 1'b0;
        case (mode)
            MODE_LOAD: begin
                q_d     = d;
                restart = 1'b1;
            end
            MODE_CLEAR: begin
                q_d     = '0;
                restart = 1'b1;
            end
            MODE_SHIFT_UP: begin
                q_d  = {q_q[WIDTH-2:0], sin_up};
                step = 1'b1;
            end
            MODE_SHIFT_DN: begin
                q_d  = {sin_dn, q_q[WIDTH-1:1]};
                step = 1'b1;
            end
            MODE_ROT_UP: begin
                q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step = 1'b1;
            end
            MODE_ROT_DN: begin
                q_d  = {q_q[0], q_q[WIDTH-1:1]};
                step = 1'b1;
            end
            default: begin
                // HOLD and reserved encoding
                q_d = q_q;
            end
        endcase
    end

    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    shift_frame_ctr #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_ctr (
        .ck         (ck),
        .rst_n      (rst_n),
        .step       (step),
        .restart    (restart),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    assign q       = q_q;
    assign sout_up = q_q[WIDTH-1];
    assign sout_dn = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;

  logic          ck = 1'b1;
  logic          rst_n;
  mode_t         mode;
  logic          sin_up;
  logic          sin_dn;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          sout_up;
  logic          sout_dn;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ck = ~ck;

  univ_shift_reg #(
    .WIDTH (W)
  ) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .mode       (mode),
    .sin_up     (sin_up),
    .sin_dn     (sin_dn),
    .d          (d),
    .q          (q),
    .sout_up    (sout_up),
    .sout_dn    (sout_dn),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  // Advance past one active (falling) edge and settle.
  task automatic tick();
    @(negedge ck);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({q, shift_cnt, frame_done} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: q=%b cnt=%0d fd=%b, want q=0000 cnt=0 fd=0",
               q, shift_cnt, frame_done);
    end
    rst_n = 1'b1;
    mode = MODE_LOAD; d = 4'b1111;
    tick();
    mode = MODE_SHIFT_UP; sin_up = 1'b1;
    tick();
    n_tests++;
    if ({q, shift_cnt} !== {4'b1111, 3'd1}) begin
      n_fail++;
      $display("FAIL reset_preload: q=%b cnt=%0d, want q=1111 cnt=1", q, shift_cnt);
    end
    // Asynchronous assertion between edges
    mode = MODE_HOLD;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({q, shift_cnt, frame_done} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: q=%b cnt=%0d fd=%b, want q=0000 cnt=0 fd=0",
               q, shift_cnt, frame_done);
    end
    #1 rst_n = 1'b1;
    tick();
    n_tests++;
    if ({q, shift_cnt, frame_done} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release_hold: q=%b cnt=%0d fd=%b, want q=0000 cnt=0 fd=0",
               q, shift_cnt, frame_done);
    end
  endtask

  task automatic test_load_hold();
    mode = MODE_LOAD; d = 4'b1010;
    tick();
    mode = MODE_HOLD; d = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done} !== {4'b1010, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: q=%b cnt=%0d fd=%b, want q=1010 cnt=0 fd=0",
                 i, q, shift_cnt, frame_done);
      end
    end
  endtask

  task automatic test_shift_up();
    logic [3:0] exp_q [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    logic [2:0] exp_c [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_f [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       sins  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    mode = MODE_CLEAR;
    tick();
    sin_dn = 1'bx;
    mode = MODE_SHIFT_UP;
    for (int i = 0; i < 4; i++) begin
      sin_up = sins[i];
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done} !== {exp_q[i], exp_c[i], exp_f[i]}) begin
        n_fail++;
        $display("FAIL shift_up[%0d]: q=%b cnt=%0d fd=%b, want q=%b cnt=%0d fd=%b",
                 i, q, shift_cnt, frame_done, exp_q[i], exp_c[i], exp_f[i]);
      end
    end
    n_tests++;
    if (sout_up !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_up_sout: sout_up=%b, want 1", sout_up);
    end
    mode = MODE_HOLD;
    tick();
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_up_pulse_width: fd=%b, want 0", frame_done);
    end
    sin_dn = 1'b0;
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q  [4] = '{4'b1100, 4'b0110, 4'b1100, 4'b1001};
    logic [2:0] exp_c  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_f  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_sd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mode = MODE_LOAD; d = 4'b1001;
    tick();
    sin_up = 1'bx; sin_dn = 1'bx;
    for (int i = 0; i < 4; i++) begin
      mode = (i < 2) ? MODE_ROT_DN : MODE_ROT_UP;
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done, sout_dn} !==
          {exp_q[i], exp_c[i], exp_f[i], exp_sd[i]}) begin
        n_fail++;
        $display("FAIL rotate[%0d]: q=%b cnt=%0d fd=%b sd=%b, want q=%b cnt=%0d fd=%b sd=%b",
                 i, q, shift_cnt, frame_done, sout_dn,
                 exp_q[i], exp_c[i], exp_f[i], exp_sd[i]);
      end
    end
    sin_up = 1'b0; sin_dn = 1'b0;
  endtask

  task automatic test_shift_dn_restart();
    logic [3:0] exp_q [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [2:0] exp_c [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_f [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    // q=1001 from previous test
    sin_up = 1'bx; sin_dn = 1'b0;
    mode = MODE_SHIFT_DN;
    tick();
    tick();
    n_tests++;
    if ({q, shift_cnt} !== {4'b0010, 3'd2}) begin
      n_fail++;
      $display("FAIL shift_dn_partial: q=%b cnt=%0d, want q=0010 cnt=2", q, shift_cnt);
    end
    mode = MODE_LOAD; d = 4'b0011;
    tick();
    n_tests++;
    if ({q, shift_cnt, frame_done} !== {4'b0011, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL shift_dn_load_restart: q=%b cnt=%0d fd=%b, want q=0011 cnt=0 fd=0",
               q, shift_cnt, frame_done);
    end
    mode = MODE_SHIFT_DN;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done} !== {exp_q[i], exp_c[i], exp_f[i]}) begin
        n_fail++;
        $display("FAIL shift_dn[%0d]: q=%b cnt=%0d fd=%b, want q=%b cnt=%0d fd=%b",
                 i, q, shift_cnt, frame_done, exp_q[i], exp_c[i], exp_f[i]);
      end
    end
    sin_up = 1'b0;
  endtask

  task automatic test_reserved_pause();
    // 1 SHIFT_UP, 3 reserved, 3 SHIFT_UP; starts at q=0000 cnt=0
    logic [2:0] modes [7] = '{3'b011, 3'b111, 3'b111, 3'b111, 3'b011, 3'b011, 3'b011};
    logic       sins  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_q [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0010, 4'b0101, 4'b1010};
    logic [2:0] exp_c [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_f [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sin_dn = 1'bx;
    for (int i = 0; i < 7; i++) begin
      mode = modes[i];
      sin_up = sins[i];
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done} !== {exp_q[i], exp_c[i], exp_f[i]}) begin
        n_fail++;
        $display("FAIL reserved_pause[%0d]: q=%b cnt=%0d fd=%b, want q=%b cnt=%0d fd=%b",
                 i, q, shift_cnt, frame_done, exp_q[i], exp_c[i], exp_f[i]);
      end
    end
    sin_dn = 1'b0;
  endtask

  task automatic test_back_to_back();
    // q=1010 cnt=0; 8 ROT_UP steps give two frames
    logic [3:0] exp_q [2] = '{4'b0101, 4'b1010};
    mode = MODE_ROT_UP;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({q, shift_cnt, frame_done} !==
          {exp_q[i % 2], 3'((i + 1) % 4), ((i % 4) == 3)}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: q=%b cnt=%0d fd=%b, want q=%b cnt=%0d fd=%b",
                 i, q, shift_cnt, frame_done, exp_q[i % 2], (i + 1) % 4,
                 ((i % 4) == 3));
      end
    end
    mode = MODE_HOLD;
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = MODE_HOLD;
    sin_up = 1'b0;
    sin_dn = 1'b0;
    d      = '0;
    #12;
    test_reset();
    test_load_hold();
    test_shift_up();
    test_rotate();
    test_shift_dn_restart();
    test_reserved_pause();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
